// File: rtl/pll_scan_pkg.sv
// Shared types and defaults for the PLL reconfiguration sequencer.
//   state_e    : sequencer FSM states
//   Def*       : default timing/length parameters
//   cnt_width  : bits needed to hold 0..max_val inclusive
package pll_scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StUpdate,
    StWaitDone,
    StAwaitReset,
    StWaitLock
  } state_e;

  localparam int unsigned AddrW              = 8;
  localparam int unsigned DefScanLen         = 144;
  localparam int unsigned DefRomLatency      = 2;
  localparam int unsigned DefScandoneTimeout = 1024;
  localparam int unsigned DefResetCycles     = 16;
  localparam int unsigned DefLockTimeout     = 1048576;

  // ceil(log2(max_val + 1)), at least 1
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((longint'(1) << w) <= longint'(max_val)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pll_scan_ctrl_if.sv
// Signal bundle between the sequencer, the reconfiguration ROM, the PLL scan port
// and the video-mode control logic.
//   master : sequencer side (drives ROM address/enable, scan chain, PLL reset, status)
//   slave  : environment side (drives start, rom_q, scandone, locked)
interface pll_scan_ctrl_if;
  import pll_scan_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [AddrW-1:0] rom_address;
  logic             rom_read_ena;
  logic             rom_q;
  logic             pll_scanclkena;
  logic             pll_scandata;
  logic             pll_configupdate;
  logic             pll_scandone;
  logic             pll_areset;
  logic             pll_locked;

  modport master (
    input  start, rom_q, pll_scandone, pll_locked,
    output busy, done, error, rom_address, rom_read_ena,
           pll_scanclkena, pll_scandata, pll_configupdate, pll_areset
  );

  modport slave (
    output start, rom_q, pll_scandone, pll_locked,
    input  busy, done, error, rom_address, rom_read_ena,
           pll_scanclkena, pll_scandata, pll_configupdate, pll_areset
  );

endinterface

// File: rtl/sync_delay.sv
// N-stage shift register, cleared by reset. Used both as a pipeline alignment
// line and as a multi-flop synchroniser.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   d_i          : input bit
//   q_o          : input delayed by Stages cycles
module sync_delay #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= (stage_q << 1) | Stages'(d_i);
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/pll_scan_ctrl.sv
// Run-time PLL reprogramming sequencer: reads ScanLen bits from the reconfiguration
// ROM, shifts them into the PLL scan chain, strobes configupdate, waits for scandone,
// pulses the PLL reset and waits for lock.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   ctrl_io      : ROM, PLL scan/reset and status signals (master side)
module pll_scan_ctrl
  import pll_scan_pkg::*;
#(
  parameter int unsigned ScanLen         = DefScanLen,
  parameter int unsigned RomLatency      = DefRomLatency,
  parameter int unsigned ScandoneTimeout = DefScandoneTimeout,
  parameter int unsigned ResetCycles     = DefResetCycles,
  parameter int unsigned LockTimeout     = DefLockTimeout
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pll_scan_ctrl_if.master ctrl_io
);

  localparam int unsigned CntMax =
      (LockTimeout > ScandoneTimeout) ?
      ((LockTimeout > ResetCycles) ? LockTimeout : ResetCycles) :
      ((ScandoneTimeout > ResetCycles) ? ScandoneTimeout : ResetCycles);
  localparam int unsigned CntW = cnt_width(CntMax);

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             pending_q, pending_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             scandone_q;
  logic             scanclkena_q, scandata_q;
  logic             rd_en, rd_en_dly, locked_sync;
  logic             scandone_rise;

  // Read enable delayed to line up with the ROM's returned data.
  sync_delay #(.Stages(RomLatency)) u_rd_align (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rd_en),
    .q_o   (rd_en_dly)
  );

  sync_delay #(.Stages(2)) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ctrl_io.pll_locked),
    .q_o   (locked_sync)
  );

  assign rd_en         = (state_q == StFetch);
  assign cnt_inc       = cnt_q + CntW'(1);
  assign scandone_rise = ctrl_io.pll_scandone & ~scandone_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    error_d   = error_q;
    done_d    = 1'b0;

    // Starts while busy merge into one pending request; this also covers a start
    // arriving on the completion cycle.
    if (ctrl_io.start && (state_q != StIdle)) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (ctrl_io.start || pending_q) begin
          state_d   = StFetch;
          addr_d    = '0;
          error_d   = 1'b0;
          pending_d = 1'b0;
        end
      end
      StFetch: begin
        if (addr_q == AddrW'(ScanLen - 1)) state_d = StDrain;
        else                               addr_d  = addr_q + AddrW'(1);
      end
      StDrain: begin
        // Delayed enable has gone low while the final bit sits on the scan port.
        if (!rd_en_dly && scanclkena_q) begin
          state_d = StUpdate;
          cnt_d   = '0;
        end
      end
      StUpdate: begin
        // The scandone timeout counts from the configupdate cycle itself.
        state_d = StWaitDone;
        cnt_d   = cnt_inc;
      end
      StWaitDone: begin
        if (scandone_rise) begin
          state_d = StAwaitReset;
          cnt_d   = '0;
        end else if (cnt_inc == CntW'(ScandoneTimeout)) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StAwaitReset: begin
        if (cnt_q == CntW'(ResetCycles - 1)) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitLock: begin
        if (locked_sync) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (cnt_inc == CntW'(LockTimeout)) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      scandone_q   <= 1'b0;
      scanclkena_q <= 1'b0;
      scandata_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      error_q      <= error_d;
      done_q       <= done_d;
      scandone_q   <= ctrl_io.pll_scandone;
      scanclkena_q <= rd_en_dly;
      scandata_q   <= rd_en_dly & ctrl_io.rom_q;
    end
  end

  assign ctrl_io.rom_read_ena     = rd_en;
  assign ctrl_io.rom_address      = rd_en ? addr_q : '0;
  assign ctrl_io.pll_scanclkena   = scanclkena_q;
  assign ctrl_io.pll_scandata     = scandata_q;
  assign ctrl_io.pll_configupdate = (state_q == StUpdate);
  assign ctrl_io.pll_areset       = (state_q == StAwaitReset);
  assign ctrl_io.busy             = (state_q != StIdle);
  assign ctrl_io.done             = done_q;
  assign ctrl_io.error            = error_q;

endmodule

// File: tb/tb_pll_scan_ctrl.sv
// Scoreboard bench for pll_scan_ctrl: a timeline model pushes expected output events
// per accepted start; a negedge monitor pops and compares each event the DUT shows.
module tb_pll_scan_ctrl;

  localparam int ScanLen = 144;
  localparam int RomLat  = 2;
  localparam int SdTo    = 1024;
  localparam int RstCyc  = 16;
  localparam int LockTo  = 2000;  // shortened lock timeout keeps the run brief

  localparam int KShift  = 0;
  localparam int KUpdate = 1;
  localparam int KAreset = 2;
  localparam int KDone   = 3;
  localparam int KError  = 4;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_scan_ctrl_if bus_if ();

  pll_scan_ctrl #(
    .ScanLen         (ScanLen),
    .RomLatency      (RomLat),
    .ScandoneTimeout (SdTo),
    .ResetCycles     (RstCyc),
    .LockTimeout     (LockTo)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ctrl_io (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  tests = 0;
  int  fails = 0;
  int  upd_cnt = 0;
  ev_t sb[$];
  bit  rom_mem [256];

  // PLL / ROM environment configuration
  int  sd_cfg = 1;
  int  lk_cfg = 0;
  int  sd_at = -1;
  int  lk_at = 1 << 30;
  bit  rom_cap = 1'b0;
  bit  rom_r1 = 1'b0;

  function automatic string kname(input int k);
    case (k)
      KShift:  return "shift";
      KUpdate: return "configupdate";
      KAreset: return "areset";
      KDone:   return "done";
      default: return "error";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic got(input int kind, input int c, input int v);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected %s at cycle %0d value %0d, expected no event", kname(kind), c, v);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || e.cyc != c || e.val != v) begin
      fails++;
      $display("FAIL %s event: got %s cycle %0d value %0d, expected %s cycle %0d value %0d",
               kname(e.kind), kname(kind), c, v, kname(e.kind), e.cyc, e.val);
    end
  endtask

  // Expected timeline for a start accepted in cycle t.
  task automatic plan(input int t, input int sd, input int lk, output int e);
    int u;
    int w;
    for (int i = 0; i < ScanLen; i++) sb.push_back('{KShift, t + RomLat + 2 + i, int'(rom_mem[i])});
    u = t + ScanLen + RomLat + 2;
    sb.push_back('{KUpdate, u, 0});
    if (sd < 0) begin
      e = u + SdTo;
      sb.push_back('{KError, e, 0});
    end else begin
      sb.push_back('{KAreset, u + sd + 1, RstCyc});
      w = u + sd + 1 + RstCyc;
      if (lk < 0) begin
        e = w + LockTo;
        sb.push_back('{KError, e, 0});
      end else begin
        e = w + lk + 3;
        sb.push_back('{KDone, e, 0});
      end
    end
  endtask

  // ROM model (2-cycle latency) and PLL model, sampled at negedge, driven after posedge.
  initial begin
    forever begin
      @(negedge clk);
      rom_cap = bus_if.rom_read_ena ? rom_mem[bus_if.rom_address] : 1'($urandom);
      if (bus_if.pll_configupdate && sd_cfg >= 0) sd_at = cyc + sd_cfg;
      if (bus_if.pll_areset) lk_at = (lk_cfg >= 0) ? cyc + 1 + lk_cfg : (1 << 30);
    end
  end

  initial begin
    bus_if.rom_q        = 1'b0;
    bus_if.pll_scandone = 1'b0;
    bus_if.pll_locked   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.rom_q        = rom_r1;
      rom_r1              = rom_cap;
      bus_if.pll_scandone = (cyc == sd_at);
      bus_if.pll_locked   = (cyc >= lk_at) && !bus_if.pll_areset;
    end
  end

  // Monitor
  initial begin
    int ar_len;
    int ar_start;
    bit err_prev;
    ar_len = 0;
    ar_start = 0;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_len = 0;
        err_prev = 1'b0;
        continue;
      end
      if (bus_if.pll_scanclkena) got(KShift, cyc, int'(bus_if.pll_scandata));
      if (bus_if.pll_configupdate) begin
        upd_cnt++;
        got(KUpdate, cyc, 0);
      end
      if (bus_if.pll_areset) begin
        if (ar_len == 0) ar_start = cyc;
        ar_len++;
      end else if (ar_len > 0) begin
        got(KAreset, ar_start, ar_len);
        ar_len = 0;
      end
      if (bus_if.done) begin
        got(KDone, cyc, 0);
        check("busy low with done", int'(bus_if.busy), 0);
      end
      if (bus_if.error && !err_prev) begin
        got(KError, cyc, 0);
        check("busy low with error", int'(bus_if.busy), 0);
      end
      err_prev = bus_if.error;
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    tick(1);
    bus_if.start = 1'b0;
  endtask

  task automatic fill_rom(input bit pattern);
    logic [7:0] a5;
    a5 = 8'hA5;
    for (int i = 0; i < 256; i++) rom_mem[i] = pattern ? a5[i % 8] : 1'($urandom);
  endtask

  task automatic run_seq(input int sd, input int lk, output int e);
    int t;
    t = cyc;
    sd_cfg = sd;
    lk_cfg = lk;
    plan(t, sd, lk, e);
    pulse_start();
    check("busy after start", int'(bus_if.busy), 1);
    check("error cleared by start", int'(bus_if.error), 0);
    check("first rom_address", int'(bus_if.rom_address), 0);
    check("rom_read_ena in fetch", int'(bus_if.rom_read_ena), 1);
    wait_until(e + 2);
  endtask

  initial begin
    int t;
    int e1;
    int e2;
    int upd0;

    bus_if.start = 1'b0;
    fill_rom(1'b1);
    tick(3);
    check("reset busy", int'(bus_if.busy), 0);
    check("reset done", int'(bus_if.done), 0);
    check("reset error", int'(bus_if.error), 0);
    check("reset rom_read_ena", int'(bus_if.rom_read_ena), 0);
    check("reset rom_address", int'(bus_if.rom_address), 0);
    check("reset scanclkena", int'(bus_if.pll_scanclkena), 0);
    check("reset configupdate", int'(bus_if.pll_configupdate), 0);
    check("reset areset", int'(bus_if.pll_areset), 0);
    rst = 1'b0;
    tick(2);

    // Nominal: 0xA5 pattern, scandone after 5, lock 100 cycles after reset release
    run_seq(5, 100, e1);

    // Scandone never arrives
    run_seq(-1, 0, e1);
    check("error sticky after scandone timeout", int'(bus_if.error), 1);
    check("idle after scandone timeout", int'(bus_if.busy), 0);

    // Lock never arrives, then a new start clears the error
    fill_rom(1'b0);
    run_seq(3, -1, e1);
    check("error sticky after lock timeout", int'(bus_if.error), 1);
    run_seq(7, 20, e1);

    // Three starts during FETCH merge into one extra run
    fill_rom(1'b0);
    upd0 = upd_cnt;
    t = cyc;
    sd_cfg = 4;
    lk_cfg = 10;
    plan(t, 4, 10, e1);
    plan(e1, 4, 10, e2);
    pulse_start();
    wait_until(t + 10);
    pulse_start();
    wait_until(t + 50);
    pulse_start();
    wait_until(t + 100);
    pulse_start();
    wait_until(e2 + 2);
    check("configupdates for merged starts", upd_cnt - upd0, 2);

    // Asynchronous reset at bit 70 of FETCH abandons the chain
    fill_rom(1'b0);
    t = cyc;
    sd_cfg = 4;
    lk_cfg = 10;
    plan(t, 4, 10, e1);
    pulse_start();
    wait_until(t + 71);
    check("rom_address at bit 70", int'(bus_if.rom_address), 70);
    #1;
    rst = 1'b1;
    #1;
    check("mid-reset busy", int'(bus_if.busy), 0);
    check("mid-reset rom_read_ena", int'(bus_if.rom_read_ena), 0);
    check("mid-reset rom_address", int'(bus_if.rom_address), 0);
    check("mid-reset scanclkena", int'(bus_if.pll_scanclkena), 0);
    check("mid-reset scandata", int'(bus_if.pll_scandata), 0);
    check("mid-reset configupdate", int'(bus_if.pll_configupdate), 0);
    sb.delete();
    upd0 = upd_cnt;
    tick(3);
    rst = 1'b0;
    tick(200);
    check("no configupdate after abandoned chain", upd_cnt - upd0, 0);
    run_seq(6, 15, e1);

    // Start on the done cycle: FETCH follows immediately
    t = cyc;
    sd_cfg = 5;
    lk_cfg = 8;
    plan(t, 5, 8, e1);
    pulse_start();
    wait_until(e1);
    check("done visible at expected cycle", int'(bus_if.done), 1);
    plan(e1, 5, 8, e2);
    pulse_start();
    check("fetch right after done", int'(bus_if.rom_read_ena), 1);
    wait_until(e2 + 2);

    // Random ROM contents and PLL response delays
    for (int i = 0; i < 3; i++) begin
      fill_rom(1'b0);
      run_seq(int'($urandom_range(1, 20)), int'($urandom_range(0, 60)), e1);
    end

    check("leftover expected events", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_scan_ctrl.md
# pll_scan_ctrl

Sequencer that reprograms the HDMI pixel PLL at run time. On a start request it walks the reconfiguration ROM bit by bit, shifts the returned serial data into the PLL scan chain, issues the config update, waits for scan completion, resets the PLL and waits for lock. It sits directly downstream of the reconfiguration ROM, driving its address/read-enable and consuming its delayed serial output; status goes back to the video-mode control logic.

## Interface
- SCAN_LEN, 144: scan-chain bits per reconfiguration; ROM addresses 0..SCAN_LEN-1
- ROM_LATENCY, 2: cycles from address/read_ena to valid rom_q
- SCANDONE_TIMEOUT, 1024: max cycles waiting for pll_scandone
- RESET_CYCLES, 16: pll_areset pulse width
- LOCK_TIMEOUT, 1048576: max cycles waiting for pll_locked
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request to reconfigure
- rom_address  out  8  ROM bit address
- rom_read_ena  out  1  ROM read enable
- rom_q  in  1  ROM serial data, valid ROM_LATENCY cycles after address
- pll_scanclkena  out  1  scan-chain shift enable
- pll_scandata  out  1  scan-chain serial data
- pll_configupdate  out  1  one-cycle update strobe
- pll_scandone  in  1  PLL finished applying scan data
- pll_areset  out  1  PLL reset
- pll_locked  in  1  PLL lock indicator (asynchronous to clock; synchronise internally, 2 flops)
- busy  out  1  high from start acceptance until done/error
- done  out  1  one-cycle pulse, successful lock
- error  out  1  sticky timeout flag, cleared on next accepted start

## Operation
- States: IDLE, FETCH, DRAIN, UPDATE, WAIT_DONE, AWAIT_RESET, WAIT_LOCK.
- IDLE: start (or pending flag) -> FETCH, clear error, address counter 0, busy=1.
- FETCH: rom_read_ena=1, rom_address=k on k-th FETCH cycle, k=0..SCAN_LEN-1; after k=SCAN_LEN-1 -> DRAIN. Address 0 is first bit shifted.
- Read-enable delayed through ROM_LATENCY-stage line; when delayed enable is high, register rom_q -> pll_scandata and assert pll_scanclkena next cycle. Exactly SCAN_LEN shift cycles, contiguous.
- DRAIN: wait until delay line empty and last bit shifted -> UPDATE.
- UPDATE: pll_configupdate=1 for one cycle -> WAIT_DONE, timeout counter cleared.
- WAIT_DONE: pll_scandone rising edge (registered 0->1) -> AWAIT_RESET; counter reaches SCANDONE_TIMEOUT -> error=1, IDLE.
- AWAIT_RESET: pll_areset=1 for RESET_CYCLES cycles -> WAIT_LOCK, counter cleared.
- WAIT_LOCK: synchronised locked=1 -> done pulse, IDLE; LOCK_TIMEOUT reached -> error=1, IDLE.
- start while busy: latched into one-deep pending flag; further starts merge. Pending serviced on return to IDLE (next cycle enters FETCH). Simultaneous start and completion: completion wins, start becomes pending.
- Counters sized ceil(log2(max+1)); no wrap; compare with equality.

## Timing
- Reset values: all outputs 0, state IDLE, pending 0, error 0, address 0.
- Reset mid-operation: immediate return to reset values; partially shifted chain abandoned (no configupdate issued).
- start at cycle T -> FETCH cycles T+1..T+SCAN_LEN; first pll_scanclkena at T+ROM_LATENCY+2; last at T+SCAN_LEN+ROM_LATENCY+1; pll_configupdate at T+SCAN_LEN+ROM_LATENCY+2.
- busy falls same cycle done or error-set appears.

## Structure
- Package pll_scan_pkg: state enum, default parameter constants, counter-width function.
- Sub-module sync_delay (N-stage shift register, reset to 0), instanced for the read-enable alignment line and the 2-flop locked synchroniser.

## Test plan
- Nominal: ROM model latency 2 with pattern 0xA5 repeated; start -> 144 contiguous scanclkena cycles, captured bits equal ROM content in address order, configupdate at T+148, areset 16 cycles, locked after 100 -> done pulse, busy low.
- Scandone never asserted -> error=1 exactly 1024 cycles after configupdate, no areset, IDLE.
- Lock timeout: locked held 0 -> error after 1048576 cycles of WAIT_LOCK; next start clears error.
- Start pulsed 3 times during FETCH -> one extra full sequence after done; total two configupdates.
- Async reset asserted at bit 70 of FETCH -> all outputs 0 same cycle, no configupdate; after release, start performs full 144-bit sequence.
- Start coincident with done cycle -> done pulse, then FETCH begins next cycle.
